// File: rtl/load_select_if.sv
// LOAD_SELECT bus between the control unit (master) and the register bank (slave).
// Signals:
//   load_valid  master -> slave  load command present
//   load_ready  slave  -> master bank can accept a command this cycle
//   load_sel    master -> slave  target register select
//   load_data   master -> slave  payload
interface load_select_if #(
    parameter int unsigned WordSize = 19,
    parameter int unsigned SelW     = 3
) ();
    logic                load_valid;
    logic                load_ready;
    logic [SelW-1:0]     load_sel;
    logic [WordSize-1:0] load_data;

    modport master (
        output load_valid,
        output load_sel,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_sel,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/load_select_regbank.sv
// Register bank sinking LOAD_SELECT commands from the control unit.
// A command is accepted in IDLE, held for one COMMIT cycle, then written into
// PC / IR / A / B / C on the COMMIT->IDLE edge. Also provides PC auto-increment
// and a registered read-back port using the same select encoding.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   bus             LOAD_SELECT handshake (slave side)
//   pc_inc_i        increment PC this cycle (ignored under freeze or PC commit)
//   freeze_i        stall: no accepts, no PC increment
//   rd_sel_i        read-back select; rd_data_o is registered, zero-extended
//   pc_o, ir_o, reg_a_o, reg_b_o, reg_c_o   register contents
//   load_ack_o      1-cycle pulse after a legal commit
//   illegal_sel_o   1-cycle pulse after a commit with sel 101-111
//   load_count_o    saturating count of legal commits
module load_select_regbank #(
    parameter int unsigned WordSize = 19,
    parameter int unsigned AddrSize = 20,
    parameter int unsigned SelW     = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    load_select_if.slave        bus,
    input  logic                pc_inc_i,
    input  logic                freeze_i,
    input  logic [SelW-1:0]     rd_sel_i,
    output logic [AddrSize-1:0] rd_data_o,
    output logic [AddrSize-1:0] pc_o,
    output logic [WordSize-1:0] ir_o,
    output logic [WordSize-1:0] reg_a_o,
    output logic [WordSize-1:0] reg_b_o,
    output logic [WordSize-1:0] reg_c_o,
    output logic                load_ack_o,
    output logic                illegal_sel_o,
    output logic [15:0]         load_count_o
);

    localparam logic [SelW-1:0] SelPc   = SelW'(0);
    localparam logic [SelW-1:0] SelIr   = SelW'(1);
    localparam logic [SelW-1:0] SelRegA = SelW'(2);
    localparam logic [SelW-1:0] SelRegB = SelW'(3);
    localparam logic [SelW-1:0] SelRegC = SelW'(4);

    typedef enum logic [0:0] {StIdle, StCommit} state_e;

    state_e              state_q, state_d;
    logic [SelW-1:0]     sel_q, sel_d;
    logic [WordSize-1:0] data_q, data_d;
    logic [AddrSize-1:0] pc_q, pc_d;
    logic [WordSize-1:0] ir_q, ir_d;
    logic [WordSize-1:0] a_q, a_d;
    logic [WordSize-1:0] b_q, b_d;
    logic [WordSize-1:0] c_q, c_d;
    logic [AddrSize-1:0] rd_data_q, rd_data_d;
    logic [15:0]         count_q, count_d;
    logic                ack_q, ack_d;
    logic                ill_q, ill_d;

    logic ready;
    logic accept;
    logic commit;
    logic legal;

    always_comb begin
        // rst_ni gating keeps ready low while reset is held, whatever the state.
        ready  = rst_ni && (state_q == StIdle) && !freeze_i;
        accept = bus.load_valid && ready;
        commit = (state_q == StCommit);
        legal  = commit && (sel_q <= SelRegC);

        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCommit;
                    sel_d   = bus.load_sel;
                    data_d  = bus.load_data;
                end
            end
            StCommit: state_d = StIdle;
        endcase

        // A PC commit takes priority over a same-edge increment.
        pc_d = pc_q;
        if (legal && (sel_q == SelPc)) begin
            pc_d = AddrSize'(data_q);
        end else if (pc_inc_i && !freeze_i) begin
            pc_d = pc_q + AddrSize'(1);
        end

        ir_d = ir_q;
        a_d  = a_q;
        b_d  = b_q;
        c_d  = c_q;
        if (legal) begin
            case (sel_q)
                SelIr:   ir_d = data_q;
                SelRegA: a_d  = data_q;
                SelRegB: b_d  = data_q;
                SelRegC: c_d  = data_q;
                default: ;
            endcase
        end

        ack_d   = legal;
        ill_d   = commit && !legal;
        count_d = (legal && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;

        // Sampled from current register values: a same-edge write is not bypassed.
        case (rd_sel_i)
            SelPc:   rd_data_d = pc_q;
            SelIr:   rd_data_d = AddrSize'(ir_q);
            SelRegA: rd_data_d = AddrSize'(a_q);
            SelRegB: rd_data_d = AddrSize'(b_q);
            SelRegC: rd_data_d = AddrSize'(c_q);
            default: rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            data_q    <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            rd_data_q <= '0;
            count_q   <= '0;
            ack_q     <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            rd_data_q <= rd_data_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            ill_q     <= ill_d;
        end
    end

    assign bus.load_ready = ready;
    assign rd_data_o      = rd_data_q;
    assign pc_o           = pc_q;
    assign ir_o           = ir_q;
    assign reg_a_o        = a_q;
    assign reg_b_o        = b_q;
    assign reg_c_o        = c_q;
    assign load_ack_o     = ack_q;
    assign illegal_sel_o  = ill_q;
    assign load_count_o   = count_q;

endmodule

// File: tb/tb_load_select_regbank.sv
module tb_load_select_regbank;

    typedef struct {
        logic        ill;
        logic [19:0] pc;
        logic [18:0] ir;
        logic [18:0] a;
        logic [18:0] b;
        logic [18:0] c;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    logic pc_inc;
    logic freeze;
    logic [2:0]  rd_sel;
    logic [19:0] rd_data;
    logic [19:0] pc;
    logic [18:0] ir, reg_a, reg_b, reg_c;
    logic        load_ack, illegal_sel;
    logic [15:0] load_count;

    // Narrow instance used only to exercise PC wrap-around in a few cycles.
    logic        s_rst_n;
    logic        s_pc_inc;
    logic [3:0]  s_rd_data, s_pc;
    logic [2:0]  s_ir, s_a, s_b, s_c;
    logic        s_ack, s_ill;
    logic [15:0] s_count;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    load_select_if #(.WordSize(19), .SelW(3)) bus ();
    load_select_if #(.WordSize(3),  .SelW(3)) s_bus ();

    load_select_regbank #(.WordSize(19), .AddrSize(20), .SelW(3)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus.slave),
        .pc_inc_i      (pc_inc),
        .freeze_i      (freeze),
        .rd_sel_i      (rd_sel),
        .rd_data_o     (rd_data),
        .pc_o          (pc),
        .ir_o          (ir),
        .reg_a_o       (reg_a),
        .reg_b_o       (reg_b),
        .reg_c_o       (reg_c),
        .load_ack_o    (load_ack),
        .illegal_sel_o (illegal_sel),
        .load_count_o  (load_count)
    );

    load_select_regbank #(.WordSize(3), .AddrSize(4), .SelW(3)) dut_small (
        .clk_i         (clk),
        .rst_ni        (s_rst_n),
        .bus           (s_bus.slave),
        .pc_inc_i      (s_pc_inc),
        .freeze_i      (1'b0),
        .rd_sel_i      (3'b000),
        .rd_data_o     (s_rd_data),
        .pc_o          (s_pc),
        .ir_o          (s_ir),
        .reg_a_o       (s_a),
        .reg_b_o       (s_b),
        .reg_c_o       (s_c),
        .load_ack_o    (s_ack),
        .illegal_sel_o (s_ill),
        .load_count_o  (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic ill, input logic [19:0] p, input logic [18:0] i,
                                input logic [18:0] a, input logic [18:0] b,
                                input logic [18:0] c, input logic [15:0] n);
        exp_t e;
        e.ill = ill; e.pc = p; e.ir = i; e.a = a; e.b = b; e.c = c; e.cnt = n;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a command until accepted; returns just after the accept edge.
    task automatic do_load(input logic [2:0] sel, input logic [18:0] data, input exp_t e);
        bit got = 0;
        bus.load_sel   = sel;
        bus.load_data  = data;
        bus.load_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.load_ready) begin
                exp_q.push_back(e);
                got = 1;
            end
            tick();
        end
        bus.load_valid = 1'b0;
        if (!got) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: every ack / illegal pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (load_ack || illegal_sel)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, illegal_sel, load_ack}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_onehot", 32'(load_ack ^ illegal_sel), 32'd1);
                check("pulse_kind",   32'(illegal_sel), 32'(e.ill));
                check("sb_pc",    32'(pc),         32'(e.pc));
                check("sb_ir",    32'(ir),         32'(e.ir));
                check("sb_a",     32'(reg_a),      32'(e.a));
                check("sb_b",     32'(reg_b),      32'(e.b));
                check("sb_c",     32'(reg_c),      32'(e.c));
                check("sb_count", 32'(load_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [19:0] rb_exp [8];
    logic [5:0]  rdy_pat;
    int          acc;

    initial begin
        rb_exp = '{20'h12346, 20'h00042, 20'h1ABCD, 20'h0BEEF, 20'h7FFFF, 20'h0, 20'h0, 20'h0};
        rst_n = 1'b0; s_rst_n = 1'b0;
        pc_inc = 1'b0; freeze = 1'b0; rd_sel = 3'b000; s_pc_inc = 1'b0;
        bus.load_valid = 1'b0; bus.load_sel = '0; bus.load_data = '0;
        s_bus.load_valid = 1'b0; s_bus.load_sel = '0; s_bus.load_data = '0;
        repeat (3) tick();

        // Reset state
        check("rst_ready",   32'(bus.load_ready), 32'd0);
        check("rst_pc",      32'(pc),          32'd0);
        check("rst_ir",      32'(ir),          32'd0);
        check("rst_a",       32'(reg_a),       32'd0);
        check("rst_b",       32'(reg_b),       32'd0);
        check("rst_c",       32'(reg_c),       32'd0);
        check("rst_rd_data", 32'(rd_data),     32'd0);
        check("rst_count",   32'(load_count),  32'd0);
        check("rst_ack",     32'(load_ack),    32'd0);
        check("rst_ill",     32'(illegal_sel), 32'd0);
        rst_n = 1'b1; s_rst_n = 1'b1;

        // PC wrap on the narrow instance: load 7, +8 -> F, +1 -> 0
        s_bus.load_valid = 1'b1; s_bus.load_sel = 3'b000; s_bus.load_data = 3'h7;
        tick();
        s_bus.load_valid = 1'b0;
        tick();
        check("small_pc_load", 32'(s_pc), 32'h7);
        s_pc_inc = 1'b1;
        repeat (8) tick();
        check("small_pc_max", 32'(s_pc), 32'hF);
        tick();
        check("small_pc_wrap", 32'(s_pc), 32'h0);
        s_pc_inc = 1'b0;

        // Load A: not visible after accept edge, visible after write edge, ack once
        do_load(3'b010, 19'h1ABCD, mk(0, 20'h0, 19'h0, 19'h1ABCD, 19'h0, 19'h0, 16'd1));
        check("a_not_yet",  32'(reg_a), 32'd0);
        check("ready_busy", 32'(bus.load_ready), 32'd0);
        tick();
        check("a_written",  32'(reg_a), 32'h1ABCD);
        check("ack_high",   32'(load_ack), 32'd1);
        tick();
        check("ack_low",    32'(load_ack), 32'd0);

        // PC load zero-extends
        do_load(3'b000, 19'h7FFFF, mk(0, 20'h7FFFF, 19'h0, 19'h1ABCD, 19'h0, 19'h0, 16'd2));
        tick();
        check("pc_zext", 32'(pc), 32'h7FFFF);
        tick();

        // PC commit wins over a same-edge increment
        do_load(3'b000, 19'h12345, mk(0, 20'h12345, 19'h0, 19'h1ABCD, 19'h0, 19'h0, 16'd3));
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        check("pc_commit_wins", 32'(pc), 32'h12345);
        tick();

        // Non-PC commit does not block increment
        do_load(3'b001, 19'h00042, mk(0, 20'h12346, 19'h42, 19'h1ABCD, 19'h0, 19'h0, 16'd4));
        pc_inc = 1'b1;
        tick();
        pc_inc = 1'b0;
        tick();

        // Illegal select: nothing written, count unchanged
        do_load(3'b110, 19'h55555, mk(1, 20'h12346, 19'h42, 19'h1ABCD, 19'h0, 19'h0, 16'd4));
        repeat (2) tick();
        do_load(3'b011, 19'h0BEEF, mk(0, 20'h12346, 19'h42, 19'h1ABCD, 19'h0BEEF, 19'h0, 16'd5));
        repeat (2) tick();
        do_load(3'b100, 19'h7FFFF,
                mk(0, 20'h12346, 19'h42, 19'h1ABCD, 19'h0BEEF, 19'h7FFFF, 16'd6));
        repeat (2) tick();

        // Read-back of every select code
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            tick();
            check($sformatf("rd_sel_%0d", i), 32'(rd_data), 32'(rb_exp[i]));
        end

        // Read-back samples before the write on the same edge
        rd_sel = 3'b010;
        do_load(3'b010, 19'h00011,
                mk(0, 20'h12346, 19'h42, 19'h11, 19'h0BEEF, 19'h7FFFF, 16'd7));
        tick();
        check("rd_no_bypass", 32'(rd_data), 32'h1ABCD);
        tick();
        check("rd_after_write", 32'(rd_data), 32'h00011);

        // Valid held 6 cycles: ready 1,0,1,0,1,0 and three acceptances
        acc = 0;
        rdy_pat = '0;
        bus.load_sel = 3'b100; bus.load_data = 19'h00777; bus.load_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rdy_pat[5-i] = bus.load_ready;
            if (bus.load_ready) begin
                acc++;
                exp_q.push_back(mk(0, 20'h12346, 19'h42, 19'h11, 19'h0BEEF, 19'h00777,
                                   16'(7 + acc)));
            end
            tick();
        end
        bus.load_valid = 1'b0;
        check("ready_pattern", 32'(rdy_pat), 32'b101010);
        check("accept_count",  32'(acc), 32'd3);
        repeat (2) tick();

        // Freeze in IDLE: no ready, no accept, PC holds despite pc_inc
        freeze = 1'b1; pc_inc = 1'b1;
        bus.load_sel = 3'b000; bus.load_data = 19'h00001; bus.load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("freeze_ready", 32'(bus.load_ready), 32'd0);
            tick();
        end
        check("freeze_pc", 32'(pc), 32'h12346);
        freeze = 1'b0; pc_inc = 1'b0; bus.load_valid = 1'b0;

        // Freeze raised during COMMIT does not block it
        do_load(3'b010, 19'h00222,
                mk(0, 20'h12346, 19'h42, 19'h222, 19'h0BEEF, 19'h00777, 16'd11));
        freeze = 1'b1;
        tick();
        freeze = 1'b0;
        check("freeze_commit_a", 32'(reg_a), 32'h222);
        repeat (2) tick();

        // Reset during COMMIT of B: discarded, no ack
        bus.load_sel = 3'b011; bus.load_data = 19'h3FFFF; bus.load_valid = 1'b1;
        @(negedge clk);
        check("pre_reset_ready", 32'(bus.load_ready), 32'd1);
        tick();
        bus.load_valid = 1'b0;
        rst_n = 1'b0;
        check("ready_in_reset", 32'(bus.load_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("reset_b",     32'(reg_b), 32'd0);
        check("reset_count", 32'(load_count), 32'd0);
        rd_sel = 3'b011;
        tick();
        check("reset_rd_b", 32'(rd_data), 32'd0);

        repeat (2) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
